shift_sequencer: RTL and testbench

Multi-cycle controller that shares one 16-bit logical shift datapath between two requesters (port 0: ALU, port 1: immediate/address path). It arbitrates round-robin and accepts one shift request at a time. Large shift amounts are split into passes of at most STEP bits per cycle. It returns the result with a one-cycle done pulse tagged with the requester ID.

---
 rtl/shift_sequencer.sv | 167 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: two-port round-robin front end sharing one
// multi-pass logical shifter; shifts at most STEP bits per cycle.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [15:0]      amt0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [15:0]      amt1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
);

    localparam int KW = $clog2(STEP) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [15:0]      rem_q;
    logic [15:0]      rem_d;
    logic             op_q;
    logic             id_q;
    logic             rr_q;
    logic [WIDTH-1:0] result_q;
    logic             done_id_q;

    logic             take0;
    logic             take1;
    logic             load_op;
    logic [WIDTH-1:0] load_a;
    logic [15:0]      load_amt;
    logic [KW-1:0]    k;

    // Round-robin arbitration, only while idle; rr_q=1 favours port 1.
    always_comb begin
        take0 = 1'b0;
        take1 = 1'b0;
        if (state_q == IDLE) begin
            take0 = req0 & (~req1 | ~rr_q);
            take1 = req1 & (~req0 | rr_q);
        end
    end

    // Operand select for the winning port.
    always_comb begin
        load_op  = op0;
        load_a   = a0;
        load_amt = amt0;
        if (take1) begin
            load_op  = op1;
            load_a   = a1;
            load_amt = amt1;
        end
    end

    // Per-pass shift distance: min(rem, STEP).
    always_comb begin
        k = KW'(STEP);
        if (rem_q < 16'(STEP)) begin
            k = rem_q[KW-1:0];
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (take0 | take1) begin
                    state_d = SHIFT;
                    if (load_amt >= 16'(WIDTH)) begin
                        acc_d = '0;
                        rem_d = '0;
                    end else begin
                        acc_d = load_a;
                        rem_d = load_amt;
                    end
                end
            end
            SHIFT: begin
                if (op_q) begin
                    acc_d = acc_q >> k;
                end else begin
                    acc_d = acc_q << k;
                end
                rem_d = rem_q - 16'(k);
                if (rem_d == 16'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job registers: accumulator, remaining count, direction, owner, pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            rem_q <= '0;
            op_q  <= 1'b0;
            id_q  <= 1'b0;
            rr_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (take0 | take1) begin
                op_q <= load_op;
                id_q <= take1;
                rr_q <= take0;
            end
        end
    end

    // Result and owner captured on the last pass; held until next job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q  <= '0;
            done_id_q <= 1'b0;
        end else if (state_q == SHIFT && state_d == DONE) begin
            result_q  <= acc_d;
            done_id_q <= id_q;
        end
    end

    // Grants are suppressed while reset is asserted.
    assign gnt0    = take0 & reset_n;
    assign gnt1    = take1 & reset_n;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and randomized jobs against a
// behavioural model of the shifter, arbitration and latency.
module tb_shift_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req0;
    logic        op0;
    logic [15:0] a0;
    logic [15:0] amt0;
    logic        req1;
    logic        op1;
    logic [15:0] a1;
    logic [15:0] amt1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [15:0] result;

    int checks;
    int failures;

    shift_sequencer #(.WIDTH(16), .STEP(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .op0     (op0),
        .a0      (a0),
        .amt0    (amt0),
        .req1    (req1),
        .op1     (op1),
        .a1      (a1),
        .amt1    (amt1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(bit op, logic [15:0] a,
                                              logic [15:0] amt);
        if (amt >= 16) return 16'h0000;
        return op ? (a >> amt) : (a << amt);
    endfunction

    function automatic int ref_cycles(logic [15:0] amt);
        if (amt == 0 || amt >= 16) return 1;
        return (int'(amt) + 3) / 4;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(bit p, bit r, bit op, logic [15:0] a,
                            logic [15:0] amt);
        if (p == 1'b0) begin
            req0 = r; op0 = op; a0 = a; amt0 = amt;
        end else begin
            req1 = r; op1 = op; a1 = a; amt1 = amt;
        end
    endtask

    task automatic wait_done(output int cnt, output bit gnt_busy);
        cnt = 0;
        gnt_busy = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (busy && (gnt0 || gnt1)) gnt_busy = 1'b1;
        end while (!done && cnt < 40);
    endtask

    task automatic do_job(string tag, bit p, bit op, logic [15:0] a,
                          logic [15:0] amt);
        int cnt;
        bit gb;
        logic [15:0] exp;
        exp = ref_shift(op, a, amt);
        set_port(!p, 1'b0, 1'b0, 16'h0, 16'h0);
        set_port(p, 1'b1, op, a, amt);
        #1;
        chk({tag, "_gnt"}, {gnt1, gnt0}, p ? 2'b10 : 2'b01);
        @(posedge clk);
        #1;
        set_port(p, 1'b0, $urandom, $urandom, $urandom);
        set_port(!p, $urandom_range(0, 1), $urandom, $urandom, $urandom);
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(cnt, gb);
        chk({tag, "_cycles"}, cnt, ref_cycles(amt));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_done_id"}, done_id, p);
        chk({tag, "_gnt_while_busy"}, gb, 1'b0);
        set_port(!p, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        chk({tag, "_after"}, {done, busy, result}, {2'b00, exp});
    endtask

    initial begin
        int cnt;
        bit gb;
        bit exp_p;
        logic [15:0] pa [2];
        logic [15:0] pamt [2];
        bit          pop [2];

        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        set_port(0, 0, 0, 16'h0, 16'h0);
        set_port(1, 0, 0, 16'h0, 16'h0);

        // 1: outputs stay quiet under reset while inputs toggle
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            set_port(0, $urandom, $urandom, $urandom, $urandom);
            set_port(1, $urandom, $urandom, $urandom, $urandom);
            #1;
            chk("rst_ctrl", {busy, done, gnt0, gnt1}, 4'b0000);
            chk("rst_result", result, 16'h0000);
        end
        set_port(0, 0, 0, 16'h0, 16'h0);
        set_port(1, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 2-4: directed single-port jobs
        do_job("amt0", 0, 0, 16'h0001, 16'd0);
        do_job("sll4", 0, 0, 16'h0001, 16'd4);
        do_job("sll9", 0, 0, 16'h0001, 16'd9);
        do_job("sll15", 0, 0, 16'h0001, 16'd15);
        do_job("srl15", 1, 1, 16'h8000, 16'd15);
        do_job("srl16", 1, 1, 16'h8000, 16'd16);
        do_job("sllffff", 1, 0, 16'h8000, 16'hFFFF);

        // randomized jobs
        for (int i = 0; i < 24; i++) begin
            logic [15:0] amt;
            if ($urandom_range(0, 3) == 0) amt = 16'($urandom);
            else amt = 16'($urandom_range(0, 17));
            do_job("rnd", 1'($urandom), 1'($urandom), 16'($urandom), amt);
        end

        // 5: both ports request continuously right after reset
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            pa[p]   = 16'($urandom) | 16'h0101;
            pamt[p] = 16'($urandom_range(1, 12));
            pop[p]  = 1'($urandom);
        end
        set_port(0, 1, pop[0], pa[0], pamt[0]);
        set_port(1, 1, pop[1], pa[1], pamt[1]);
        exp_p = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("rr_gnt", {gnt1, gnt0}, exp_p ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            wait_done(cnt, gb);
            chk("rr_cycles", cnt, ref_cycles(pamt[exp_p]));
            chk("rr_done_id", done_id, exp_p);
            chk("rr_result", result,
                ref_shift(pop[exp_p], pa[exp_p], pamt[exp_p]));
            chk("rr_gnt_while_busy", gb, 1'b0);
            if (j == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(posedge clk);
            exp_p = !exp_p;
        end
        #1;
        do_job("nz", 0, 0, 16'h00F3, 16'd2);

        // 6: reset during the 2nd SHIFT cycle of an amt=12 job
        set_port(0, 1, 0, 16'h0007, 16'd12);
        #1;
        chk("mid_gnt", {gnt1, gnt0}, 2'b01);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_busy", busy, 1'b1);
        set_port(1, 1, 1, 16'hFFFF, 16'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {busy, done, gnt0, gnt1}, 4'b0000);
        chk("mid_rst_result", result, 16'h0000);
        gb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) gb = 1'b1;
        end
        chk("mid_rst_quiet", gb, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("mid_regnt", {gnt1, gnt0}, 2'b01);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(cnt, gb);
        chk("mid_cycles", cnt, 3);
        chk("mid_result", result, 16'h7000);
        chk("mid_done_id", done_id, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_after", {done, busy}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
